// File: rtl/fetch_inject_unit_pkg.sv
// Shared opcode constants, fetch-inject state encoding and injected-word helper.
// Used by the fetch inject unit and the control unit.
package fetch_inject_unit_pkg;

    localparam int OPCODE_W = 5;
    localparam int INSTR_W  = 16;

    localparam logic [OPCODE_W-1:0] OP_PUSH_PC_LOW  = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_PUSH_PC_HIGH = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_POP_PC_LOW   = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_PUSH_FLAGS   = 5'b11111;
    localparam logic [OPCODE_W-1:0] OP_POP_FLAGS    = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_NOP          = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_RET          = 5'b11101;
    localparam logic [OPCODE_W-1:0] OP_RTI          = 5'b11110;
    localparam logic [OPCODE_W-1:0] OP_LDM          = 5'b10010;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INT_LOW   = 3'd1,
        INT_HIGH  = 3'd2,
        INT_FLAGS = 3'd3,
        RET_LOW   = 3'd4,
        RTI_LOW   = 3'd5,
        RTI_FLAGS = 3'd6,
        IMM       = 3'd7
    } fetch_state_e;

    // An injected instruction is the opcode in [15:11] with all operand bits zero.
    function automatic logic [INSTR_W-1:0] inject_word(input logic [OPCODE_W-1:0] op);
        return {op, {(INSTR_W-OPCODE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_inject_unit.sv
// Fetch-stage injector: replaces the fetched word with PUSH/POP micro-sequences
// for interrupt entry, RET and RTI, and turns the LDM immediate into a NOP.
// Outputs are registered; the first injected word appears one cycle after the
// triggering edge.
// Optional build macro: FETCH_INT_LATCH_EN -- remember an INT rising edge that
// arrives outside IDLE (or loses to a decode request) and service it on the
// next IDLE cycle. Without it such edges are dropped.
//
// state     | meaning
// IDLE      | pass instr_mem through, PC advances
// INT_LOW   | inject PUSH_PC_LOW  (A800)
// INT_HIGH  | inject PUSH_PC_HIGH (B000)
// INT_FLAGS | inject PUSH_FLAGS   (F800)
// RET_LOW   | inject POP_PC_LOW   (B800)
// RTI_LOW   | inject POP_PC_LOW   (B800)
// RTI_FLAGS | inject POP_FLAGS    (7800)
// IMM       | LDM immediate word replaced by NOP, PC advances past it
module fetch_inject_unit
    import fetch_inject_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               INT_signal,
    input  logic [INSTR_W-1:0] instr_mem,
    input  logic               stall,
    input  logic               dec_ret,
    input  logic               dec_rti,
    input  logic               dec_ldm,
    output logic [INSTR_W-1:0] instr_out,
    output logic               pc_en,
    output logic               int_busy
);

    fetch_state_e       state_q, state_d;
    logic               int_q;
    logic               int_rise;
    logic               int_req;
    logic [INSTR_W-1:0] instr_d;
    logic               pc_en_d;
    logic               busy_d;
`ifdef FETCH_INT_LATCH_EN
    logic               pending_q, pending_d;
`endif

    // Next state, next registered outputs and pending-interrupt bookkeeping.
    always_comb begin
        int_rise = INT_signal & ~int_q;
`ifdef FETCH_INT_LATCH_EN
        int_req  = int_rise | pending_q;
`else
        int_req  = int_rise;
`endif
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dec_rti)      state_d = RTI_LOW;
                else if (dec_ret) state_d = RET_LOW;
                else if (dec_ldm) state_d = IMM;
                else if (int_req) state_d = INT_LOW;
            end
            INT_LOW:   state_d = INT_HIGH;
            INT_HIGH:  state_d = INT_FLAGS;
            INT_FLAGS: state_d = IDLE;
            RET_LOW:   state_d = IDLE;
            RTI_LOW:   state_d = RTI_FLAGS;
            RTI_FLAGS: state_d = IDLE;
            IMM:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        instr_d = instr_mem;
        pc_en_d = 1'b1;
        busy_d  = 1'b0;
        unique case (state_d)
            INT_LOW:   begin instr_d = inject_word(OP_PUSH_PC_LOW);  pc_en_d = 1'b0; busy_d = 1'b1; end
            INT_HIGH:  begin instr_d = inject_word(OP_PUSH_PC_HIGH); pc_en_d = 1'b0; busy_d = 1'b1; end
            INT_FLAGS: begin instr_d = inject_word(OP_PUSH_FLAGS);   pc_en_d = 1'b0; busy_d = 1'b1; end
            RET_LOW,
            RTI_LOW:   begin instr_d = inject_word(OP_POP_PC_LOW);   pc_en_d = 1'b0; busy_d = 1'b1; end
            RTI_FLAGS: begin instr_d = inject_word(OP_POP_FLAGS);    pc_en_d = 1'b0; busy_d = 1'b1; end
            IMM:       begin instr_d = inject_word(OP_NOP);          pc_en_d = 1'b1; busy_d = 1'b0; end
            default:   ;
        endcase

`ifdef FETCH_INT_LATCH_EN
        // An edge not consumed this cycle (busy, or beaten by RET/RTI/LDM) is kept.
        pending_d = pending_q;
        if (state_d == INT_LOW) pending_d = 1'b0;
        else if (int_rise)      pending_d = 1'b1;
`endif
    end

    // State, INT edge register and output registers; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            int_q     <= 1'b0;
            instr_out <= '0;
            pc_en     <= 1'b0;
            int_busy  <= 1'b0;
`ifdef FETCH_INT_LATCH_EN
            pending_q <= 1'b0;
`endif
        end else if (!stall) begin
            state_q   <= state_d;
            int_q     <= INT_signal;
            instr_out <= instr_d;
            pc_en     <= pc_en_d;
            int_busy  <= busy_d;
`ifdef FETCH_INT_LATCH_EN
            pending_q <= pending_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_inject_unit.sv
module tb_fetch_inject_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT_signal;
    logic [15:0] instr_mem;
    logic        stall;
    logic        dec_ret;
    logic        dec_rti;
    logic        dec_ldm;
    logic [15:0] instr_out;
    logic        pc_en;
    logic        int_busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

`ifdef FETCH_INT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_inject_unit dut (
        .clk        (clk),
        .rst        (rst),
        .INT_signal (INT_signal),
        .instr_mem  (instr_mem),
        .stall      (stall),
        .dec_ret    (dec_ret),
        .dec_rti    (dec_rti),
        .dec_ldm    (dec_ldm),
        .instr_out  (instr_out),
        .pc_en      (pc_en),
        .int_busy   (int_busy)
    );

    // Drive one cycle of inputs, queue the expected registered output, then
    // compare against the DUT one time unit after the edge.
    task automatic cyc(input logic r, input logic i, input logic [15:0] mem,
                       input logic stl, input logic rt, input logic rti, input logic ldm,
                       input logic [15:0] e_instr, input logic e_pc, input logic e_busy,
                       input string tag);
        logic [17:0] e;
        string       t;
        @(negedge clk);
        rst = r; INT_signal = i; instr_mem = mem; stall = stl;
        dec_ret = rt; dec_rti = rti; dec_ldm = ldm;
        exp_q.push_back({e_instr, e_pc, e_busy});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert ({instr_out, pc_en, int_busy} === e)
            else begin
                n_fails++;
                $error("FAIL %s: got instr=%h pc_en=%b busy=%b, expected instr=%h pc_en=%b busy=%b",
                       t, instr_out, pc_en, int_busy, e[17:2], e[1], e[0]);
            end
        end
    endtask

    // Passthrough expected in IDLE: instr_mem registered, pc_en=1, busy=0.
    task automatic pass(input logic i, input logic [15:0] mem, input string tag);
        cyc(1'b0, i, mem, 1'b0, 1'b0, 1'b0, 1'b0, mem, 1'b1, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; INT_signal = 1'b0; instr_mem = 16'h4800; stall = 1'b0;
        dec_ret = 1'b0; dec_rti = 1'b0; dec_ldm = 1'b0;

        // Reset for two cycles, then first passthrough with pc_en high.
        cyc(1, 0, 16'h4800, 0, 0, 0, 0, 16'h0000, 0, 0, "reset_0");
        cyc(1, 0, 16'h4800, 0, 0, 0, 0, 16'h0000, 0, 0, "reset_1");
        pass(0, 16'h4800, "first_after_reset");

        // One-cycle INT pulse.
        cyc(0, 1, 16'h1234, 0, 0, 0, 0, 16'hA800, 0, 1, "int_low");
        cyc(0, 0, 16'h1234, 0, 0, 0, 0, 16'hB000, 0, 1, "int_high");
        cyc(0, 0, 16'h1234, 0, 0, 0, 0, 16'hF800, 0, 1, "int_flags");
        pass(0, 16'h5555, "int_done_pass");

        // INT held high: no retrigger until it drops and rises again.
        cyc(0, 1, 16'h0101, 0, 0, 0, 0, 16'hA800, 0, 1, "held_low");
        cyc(0, 1, 16'h0101, 0, 0, 0, 0, 16'hB000, 0, 1, "held_high");
        cyc(0, 1, 16'h0101, 0, 0, 0, 0, 16'hF800, 0, 1, "held_flags");
        pass(1, 16'h0202, "held_no_retrig_0");
        pass(1, 16'h0303, "held_no_retrig_1");
        pass(0, 16'h0404, "held_released");
        cyc(0, 1, 16'h0505, 0, 0, 0, 0, 16'hA800, 0, 1, "reedge_low");
        cyc(0, 0, 16'h0505, 0, 0, 0, 0, 16'hB000, 0, 1, "reedge_high");
        cyc(0, 0, 16'h0505, 0, 0, 0, 0, 16'hF800, 0, 1, "reedge_flags");
        pass(0, 16'h0606, "reedge_pass");

        // RTI, RET, LDM.
        cyc(0, 0, 16'h1111, 0, 0, 1, 0, 16'hB800, 0, 1, "rti_low");
        cyc(0, 0, 16'h1111, 0, 0, 0, 0, 16'h7800, 0, 1, "rti_flags");
        pass(0, 16'h2222, "rti_pass");
        cyc(0, 0, 16'h3333, 0, 1, 0, 0, 16'hB800, 0, 1, "ret_low");
        pass(0, 16'h4444, "ret_pass");
        cyc(0, 0, 16'h9000, 0, 0, 0, 1, 16'h0000, 1, 0, "ldm_imm");
        pass(0, 16'h6666, "ldm_pass");

        // Priority: all requests at once -> RTI; decode flags ignored mid-sequence.
        cyc(0, 0, 16'h7777, 0, 1, 1, 1, 16'hB800, 0, 1, "prio_rti");
        cyc(0, 0, 16'h7777, 0, 1, 0, 1, 16'h7800, 0, 1, "prio_ignore_dec");
        pass(0, 16'h8888, "prio_pass");
        cyc(0, 0, 16'h7777, 0, 1, 0, 1, 16'hB800, 0, 1, "prio_ret_over_ldm");
        pass(0, 16'h8889, "prio_pass2");

        // INT together with RET: RET wins, INT serviced later only when latched.
        cyc(0, 1, 16'hAAAA, 0, 1, 0, 0, 16'hB800, 0, 1, "int_ret_ret");
        pass(0, 16'hABAB, "int_ret_pass");
        if (LATCH) begin
            cyc(0, 0, 16'hACAC, 0, 0, 0, 0, 16'hA800, 0, 1, "int_ret_latched_low");
            cyc(0, 0, 16'hACAC, 0, 0, 0, 0, 16'hB000, 0, 1, "int_ret_latched_high");
            cyc(0, 0, 16'hACAC, 0, 0, 0, 0, 16'hF800, 0, 1, "int_ret_latched_flags");
        end else begin
            pass(0, 16'hACAC, "int_ret_dropped");
        end
        pass(0, 16'hADAD, "int_ret_done");

        // Stall for three cycles while in INT_HIGH.
        cyc(0, 1, 16'hC0C0, 0, 0, 0, 0, 16'hA800, 0, 1, "stall_low");
        cyc(0, 0, 16'hC0C0, 0, 0, 0, 0, 16'hB000, 0, 1, "stall_high");
        cyc(0, 0, 16'hC1C1, 1, 1, 0, 0, 16'hB000, 0, 1, "stall_hold_0");
        cyc(0, 0, 16'hC2C2, 1, 0, 1, 0, 16'hB000, 0, 1, "stall_hold_1");
        cyc(0, 0, 16'hC3C3, 1, 0, 0, 1, 16'hB000, 0, 1, "stall_hold_2");
        cyc(0, 0, 16'hC4C4, 0, 0, 0, 0, 16'hF800, 0, 1, "stall_flags");
        pass(0, 16'h1111, "stall_pass");
        cyc(0, 0, 16'h2222, 1, 0, 0, 0, 16'h1111, 1, 0, "stall_idle_freeze");
        pass(0, 16'h2323, "stall_idle_release");

        // INT pulse during RTI_LOW.
        cyc(0, 0, 16'hD0D0, 0, 0, 1, 0, 16'hB800, 0, 1, "rti_int_low");
        cyc(0, 1, 16'hD0D0, 0, 0, 0, 0, 16'h7800, 0, 1, "rti_int_flags");
        pass(0, 16'hD1D1, "rti_int_idle");
        if (LATCH) begin
            cyc(0, 0, 16'hD2D2, 0, 0, 0, 0, 16'hA800, 0, 1, "rti_int_latched_low");
            cyc(0, 0, 16'hD2D2, 0, 0, 0, 0, 16'hB000, 0, 1, "rti_int_latched_high");
            cyc(0, 0, 16'hD2D2, 0, 0, 0, 0, 16'hF800, 0, 1, "rti_int_latched_flags");
        end else begin
            pass(0, 16'hD2D2, "rti_int_dropped");
        end
        pass(0, 16'hD3D3, "rti_int_done");

        // Reset (with stall) aborts a running sequence.
        cyc(0, 1, 16'hE0E0, 0, 0, 0, 0, 16'hA800, 0, 1, "abort_low");
        cyc(1, 0, 16'hE0E0, 1, 0, 0, 0, 16'h0000, 0, 0, "abort_reset");
        pass(0, 16'hABCD, "abort_release");
        pass(0, 16'hABCE, "abort_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_inject_unit.md
FETCH_INJECT_UNIT -- requirements
Module: fetch_inject_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port INT_signal, input, 1 bit: external interrupt request level, sampled on the rising edge.
REQ-004 SHALL have port instr_mem, input, 16 bits: word read from instruction memory at the current PC; opcode is bits [15:11].
REQ-005 SHALL have port stall, input, 1 bit: pipeline hold; when high, state and outputs are frozen.
REQ-006 SHALL have port dec_ret, input, 1 bit: RET opcode 11101 currently in decode.
REQ-007 SHALL have port dec_rti, input, 1 bit: RTI opcode 11110 currently in decode.
REQ-008 SHALL have port dec_ldm, input, 1 bit: LDM opcode 10010 currently in decode, which drives fetch_NOP.
REQ-009 SHALL have port instr_out, output, 16 bits: word written into the fetch/decode buffer.
REQ-010 SHALL have port pc_en, output, 1 bit: the PC may advance this cycle.
REQ-011 SHALL have port int_busy, output, 1 bit: an injection sequence is in progress.

Function
REQ-012 SHALL implement these FSM states: IDLE, INT_LOW, INT_HIGH, INT_FLAGS, RET_LOW, RTI_LOW, RTI_FLAGS and IMM.
REQ-013 SHALL, in IDLE, set instr_out = instr_mem, pc_en = 1 and int_busy = 0.
REQ-014 SHALL, for an injected opcode X, set instr_out = {X, 11'b0}, pc_en = 0 and int_busy = 1.
REQ-015 SHALL inject the following opcodes: INT_LOW → 10101, INT_HIGH → 10110, INT_FLAGS → 11111, RET_LOW → 10111, RTI_LOW → 10111, RTI_FLAGS → 01111.
REQ-016 SHALL, in IMM, set instr_out = 16'h0000 and pc_en = 1, so the immediate word is skipped as a NOP.
REQ-017 SHALL apply these transitions from IDLE, in priority order: dec_rti → RTI_LOW; dec_ret → RET_LOW; dec_ldm → IMM; INT_signal → INT_LOW; otherwise remain in IDLE.
REQ-018 SHALL follow the interrupt sequence INT_LOW → INT_HIGH → INT_FLAGS → IDLE, one cycle each.
REQ-019 SHALL follow the return sequences RET_LOW → IDLE, RTI_LOW → RTI_FLAGS → IDLE, and IMM → IDLE.
REQ-020 SHALL have a latency of exactly 1 cycle from the triggering edge to the first injected word.
REQ-021 SHALL hold the state and all outputs unchanged while stall = 1, with no transition taken.
REQ-022 SHALL ignore dec_ret, dec_rti and dec_ldm when not in IDLE, because injected words never carry those opcodes.
REQ-023 SHALL, when INT_signal and dec_ret are high in the same cycle, service the RET and handle the interrupt according to REQ-029.
REQ-024 SHALL keep INT_signal held high after a completed sequence from retriggering, unless it first returns low (edge qualification on an internal registered copy).

Reset
REQ-025 SHALL, on rst = 1 at a rising edge, set state = IDLE, instr_out = 16'h0000, pc_en = 0, int_busy = 0, and clear the INT edge register and pending flag.
REQ-026 SHALL have rst override stall, and SHALL have rst abort any in-progress sequence with no further injected words.
REQ-027 SHALL drive pc_en = 1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL provide the macro FETCH_INT_LATCH_EN.
REQ-029 SHALL, with FETCH_INT_LATCH_EN defined, latch an INT rising edge arriving while not in IDLE into a pending flag, take it on the next IDLE cycle at priority below REQ-017 items 1–3, and clear the flag on entry to INT_LOW.
REQ-030 SHALL, without FETCH_INT_LATCH_EN, ignore an INT edge arriving outside IDLE.

Structure
REQ-031 SHALL place the opcode constants (PUSH_PC_LOW 10101, PUSH_PC_HIGH 10110, POP_PC_LOW 10111, PUSH_FLAGS 11111, POP_FLAGS 01111, NOP 00000, RET, RTI, LDM) and the state enum in a shared package used by both this block and the control unit.
REQ-032 SHALL be a single module with no sub-module; the FSM and edge detector are inline.

Verification
REQ-033 SHALL cover: rst for 2 cycles, then instr_mem = 16'h4800 → instr_out = 16'h4800 and pc_en = 1 on the first cycle after release.
REQ-034 SHALL cover: a 1-cycle INT pulse in IDLE → instr_out = A800, B000, F800 on consecutive cycles with pc_en = 0, then an instr_mem passthrough.
REQ-035 SHALL cover: dec_rti = 1 → B800 then 7800, followed by IDLE; dec_ret = 1 → a single B800.
REQ-036 SHALL cover: dec_ldm = 1 → one cycle of 0000 with pc_en = 1, then IDLE.
REQ-037 SHALL cover: stall held for 3 cycles during INT_HIGH → B000 held for 3 cycles, then F800.
REQ-038 SHALL cover: an INT pulse during RTI_LOW → a sequence starting A800 after RTI_FLAGS with FETCH_INT_LATCH_EN defined, and no injection without it.
